serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Sequencing controller that reuses one 1-bit full-adder slice over WIDTH clocked steps to add two WIDTH-bit operands on the EGO1 board. The block latches operands from the switches on a start press and feeds one bit pair plus the stored carry to the slice per step. It shifts the sum bits into a result register and reports completion on LEDs. It sits between the switch/button inputs and the LED outputs, in place of a WIDTH-wide ripple adder.

## Interface
- WIDTH, 4: operand width in bits; legal range 2..16.
- STEP_DIV, 1: clock cycles per bit step; legal range 1..2^24. Large values let the operator watch the steps on LEDs.
- clk_pin  input  1  system clock; all state updates on rising edge.
- rst_n_pin  input  1  reset; asynchronous and active-low.
- start_pin  input  1  start request from the button; asynchronous level, synchronized internally.
- a_pin  input  WIDTH  operand A from switches.
- b_pin  input  WIDTH  operand B from switches.
- cin_pin  input  1  carry-in from switch.
- sum_pin  output  WIDTH  last completed sum.
- cout_pin  output  1  last completed carry-out.
- busy_pin  output  1  high while a bit-serial add is in progress.
- done_pin  output  1  high from completion until the next accepted start.
- bit_idx_pin  output  ceil(log2(WIDTH))  index of the bit being processed; 0 when not busy.

## Operation
- **Start detection.** start_pin passes through a 2-FF synchronizer (s1, s2) into a delay FF s3. The start pulse is s2 & ~s3, one cycle per rising edge of start_pin.
- **State IDLE.** Reached after reset.
  - A start pulse latches a_pin into shift register A and b_pin into shift register B.
  - Carry FF loads cin_pin. The prescaler, bit index and sum shift register clear.
  - busy_pin goes to 1 and done_pin goes to 0. Next state is ADD.
- **State ADD.**
  - Prescaler counts 0..STEP_DIV-1 and wraps. A step fires in a cycle where prescaler == STEP_DIV-1.
  - Slice inputs are a = A[0], b = B[0], c = carry.
  - Slice outputs are s = a^b^c and co = ab|ac|bc.
  - On a step, A and B shift right with 0 filled at the MSB. The sum shift register shifts right with s inserted at the MSB. Carry loads co and the bit index increments.
  - The step with bit index WIDTH-1 is the final step. It:
    - writes sum_pin ← {s, sumsh[WIDTH-1:1]} and cout_pin ← co;
    - sets done_pin ← 1, busy_pin ← 0 and bit index ← 0;
    - moves the state to DONE.
- **State DONE.** sum_pin, cout_pin and done_pin hold. A start pulse performs the same load as in IDLE and enters ADD.
- **Start pulse during ADD.** Ignored; the add in progress is not restarted.
- **Input changes during ADD.** Changes on a_pin, b_pin and cin_pin have no effect; operands are captured only at load.
- **sum_pin and cout_pin during ADD.** Both keep the previous result and never show partial values.
- **Arithmetic.** {cout_pin, sum_pin} = a_pin + b_pin + cin_pin, modulo 2^(WIDTH+1), using the values sampled at load.
- **Reset values.** On rst_n_pin = 0, whether idle or mid-operation, all of the following clear immediately:
  - state → IDLE;
  - sum_pin, cout_pin, busy_pin, done_pin and bit_idx_pin → 0;
  - shift registers, carry and prescaler → 0;
  - synchronizer FFs s1, s2, s3 → 0.
- **Start held across reset.** If start_pin is high when reset deasserts, that counts as one rising edge: s2 rises after release, so exactly one start pulse occurs.

## Timing
- **Start acceptance.** start_pin first sampled high at edge k. s2 is high after edge k+1. The load occurs at edge k+2, where busy_pin rises and done_pin falls.
- **Step timing.** Bit step j (j = 0..WIDTH-1) fires at edge k+2+(j+1)·STEP_DIV. bit_idx_pin equals j+1 after that edge, except after the final step.
- **Completion.** At edge k+2+WIDTH·STEP_DIV, sum_pin and cout_pin update, done_pin rises and busy_pin falls.
- **Latency.** Start to done is 2 + WIDTH·STEP_DIV cycles. Example: WIDTH=4, STEP_DIV=1 gives 6 cycles.
- **Back-to-back operation.** A new start edge may be accepted in DONE from the cycle after completion. There is no dead cycle beyond the synchronizer.
- **Asynchronous reset.** Takes effect without waiting for a clock edge. The first state update occurs on the first rising edge after rst_n_pin goes high.

## Test plan
- **Basic add.** WIDTH=4, STEP_DIV=1; A=0101, B=0011, cin=0; start edge at k → busy_pin=1 at k+2, done_pin=1 at k+6, sum_pin=1000, cout_pin=0.
- **Carry propagation.** A=1111, B=0001, cin=0 → sum_pin=0000, cout_pin=1.
- **Maximum operands.** A=1111, B=1111, cin=1 → sum_pin=1111, cout_pin=1.
- **Inputs ignored while busy.**
  - Stimulus: during ADD, give a second start edge and change A to 0000.
  - Required response: the original result is unchanged and there is exactly one done_pin rise. sum_pin keeps the prior result until completion.
- **Reset mid-operation.** Assert rst_n_pin=0 at bit index 2 → all outputs become 0 immediately. After release, state is IDLE, and a new start edge produces a correct fresh result.
- **Slow stepping.** STEP_DIV=3: bit_idx_pin steps every 3 cycles and done_pin rises at k+14. Then a start pressed in DONE reloads the new operands and clears done_pin at the load edge.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//
// Adds two WIDTH-bit operands using a single 1-bit full-adder slice that is
// reused over WIDTH bit steps, LSB first. Each step lasts STEP_DIV clock
// cycles, so a large STEP_DIV makes the progress visible on LEDs.
//
// Ports:
//   clk_pin      system clock, rising-edge active
//   rst_n_pin    asynchronous active-low reset
//   start_pin    start button level (asynchronous, synchronized here)
//   a_pin        operand A (sampled only when an add is launched)
//   b_pin        operand B (sampled only when an add is launched)
//   cin_pin      carry-in  (sampled only when an add is launched)
//   sum_pin      sum of the last completed add
//   cout_pin     carry-out of the last completed add
//   busy_pin     high while an add is in progress
//   done_pin     high from completion until the next accepted start
//   bit_idx_pin  index of the bit being processed, 0 when not busy
module serial_adder_ctrl #(
    parameter int WIDTH    = 4,
    parameter int STEP_DIV = 1,
    localparam int IDX_W   = $clog2(WIDTH)
) (
    input  logic             clk_pin,
    input  logic             rst_n_pin,
    input  logic             start_pin,
    input  logic [WIDTH-1:0] a_pin,
    input  logic [WIDTH-1:0] b_pin,
    input  logic             cin_pin,
    output logic [WIDTH-1:0] sum_pin,
    output logic             cout_pin,
    output logic             busy_pin,
    output logic             done_pin,
    output logic [IDX_W-1:0] bit_idx_pin
);

    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sumsh_q, sumsh_d;
    logic             carry_q, carry_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic start_pulse;
    logic step;
    logic slice_s;
    logic slice_co;

    always_comb begin
        state_d = state_q;
        s1_d    = start_pin;
        s2_d    = s1_q;
        s3_d    = s2_q;
        a_d     = a_q;
        b_d     = b_q;
        sumsh_d = sumsh_q;
        carry_d = carry_q;
        pre_d   = pre_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = done_q;

        // One pulse per rising edge of the synchronized button level.
        start_pulse = s2_q & ~s3_q;
        step        = (pre_q == PRE_LAST);

        // The shared full-adder slice.
        slice_s  = a_q[0] ^ b_q[0] ^ carry_q;
        slice_co = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // sum/cout are left untouched so the previous result stays
                // on the LEDs for the whole duration of the next add.
                if (start_pulse) begin
                    a_d     = a_pin;
                    b_d     = b_pin;
                    carry_d = cin_pin;
                    pre_d   = '0;
                    idx_d   = '0;
                    sumsh_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                // Start pulses are deliberately not looked at here.
                pre_d = step ? '0 : pre_q + 1'b1;
                if (step) begin
                    a_d     = {1'b0, a_q[WIDTH-1:1]};
                    b_d     = {1'b0, b_q[WIDTH-1:1]};
                    sumsh_d = {slice_s, sumsh_q[WIDTH-1:1]};
                    carry_d = slice_co;
                    if (idx_q == IDX_LAST) begin
                        sum_d   = {slice_s, sumsh_q[WIDTH-1:1]};
                        cout_d  = slice_co;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pin or negedge rst_n_pin) begin
        if (!rst_n_pin) begin
            state_q <= ST_IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sumsh_q <= '0;
            carry_q <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sumsh_q <= sumsh_d;
            carry_q <= carry_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sum_pin     = sum_q;
    assign cout_pin    = cout_q;
    assign busy_pin    = busy_q;
    assign done_pin    = done_q;
    assign bit_idx_pin = idx_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: one instance with STEP_DIV=1 and one with
// STEP_DIV=3, both WIDTH=4. Expected results go into per-instance queues when
// a start is driven and are popped when done_pin rises.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a, b;
    logic       cin;
    logic       start1, start3;

    logic [3:0] sum1, sum3;
    logic       cout1, cout3, busy1, busy3, done1, done3;
    logic [1:0] idx1, idx3;

    int checks = 0;
    int errors = 0;

    logic [4:0] q1[$];
    logic [4:0] q3[$];
    logic [4:0] last_exp1 = '0;
    int         rises1 = 0;
    logic       done1_prev = 1'b0;
    logic       done3_prev = 1'b0;

    typedef struct {
        logic [3:0] av;
        logic [3:0] bv;
        logic       cv;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(4), .STEP_DIV(1)) dut1 (
        .clk_pin(clk), .rst_n_pin(rst_n), .start_pin(start1),
        .a_pin(a), .b_pin(b), .cin_pin(cin),
        .sum_pin(sum1), .cout_pin(cout1), .busy_pin(busy1),
        .done_pin(done1), .bit_idx_pin(idx1)
    );

    serial_adder_ctrl #(.WIDTH(4), .STEP_DIV(3)) dut3 (
        .clk_pin(clk), .rst_n_pin(rst_n), .start_pin(start3),
        .a_pin(a), .b_pin(b), .cin_pin(cin),
        .sum_pin(sum3), .cout_pin(cout3), .busy_pin(busy3),
        .done_pin(done3), .bit_idx_pin(idx3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Scoreboard: compare the result whenever done rises.
    always @(negedge clk) begin
        logic [4:0] e;
        if (done1 && !done1_prev) begin
            rises1++;
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1 unexpected done actual=%0h required=none", {cout1, sum1});
            end else begin
                e = q1.pop_front();
                check("dut1 result", {27'd0, cout1, sum1}, {27'd0, e});
                last_exp1 = e;
            end
        end
        if (done3 && !done3_prev) begin
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut3 unexpected done actual=%0h required=none", {cout3, sum3});
            end else begin
                e = q3.pop_front();
                check("dut3 result", {27'd0, cout3, sum3}, {27'd0, e});
            end
        end
        done1_prev = done1;
        done3_prev = done3;
    end

    // Full add on dut1 with cycle-exact latency checks (start sampled at edge k).
    task automatic do_add(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                          input logic [4:0] exp);
        a = av; b = bv; cin = cv; start1 = 1'b1;
        q1.push_back(exp);
        @(posedge clk); #1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 3) start1 = 1'b0;
            if (c == 1) check("busy before load", {31'd0, busy1}, 32'd0);
            if (c == 2) begin
                check("busy at load", {31'd0, busy1}, 32'd1);
                check("done cleared at load", {31'd0, done1}, 32'd0);
            end
            if (c >= 2 && c <= 5)
                check("result held in add", {27'd0, cout1, sum1}, {27'd0, last_exp1});
            if (c >= 3 && c <= 5)
                check("bit index", {30'd0, idx1}, c - 2);
            if (c == 5) check("done not early", {31'd0, done1}, 32'd0);
            if (c == 6) begin
                check("done at k+6", {31'd0, done1}, 32'd1);
                check("busy cleared", {31'd0, busy1}, 32'd0);
                check("index cleared", {30'd0, idx1}, 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int n;
        int exp_idx;

        vecs[0] = '{4'b0101, 4'b0011, 1'b0, 5'b01000};
        vecs[1] = '{4'b1111, 4'b0001, 1'b0, 5'b10000};
        vecs[2] = '{4'b1111, 4'b1111, 1'b1, 5'b11111};
        vecs[3] = '{4'b0000, 4'b0000, 1'b0, 5'b00000};
        vecs[4] = '{4'b0000, 4'b0000, 1'b1, 5'b00001};
        vecs[5] = '{4'b1010, 4'b0101, 1'b1, 5'b10000};
        vecs[6] = '{4'b0110, 4'b0111, 1'b0, 5'b01101};
        vecs[7] = '{4'b1001, 4'b1001, 1'b1, 5'b10011};

        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; start1 = 1'b0; start3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset sum", {28'd0, sum1}, 32'd0);
        check("reset cout", {31'd0, cout1}, 32'd0);
        check("reset busy", {31'd0, busy1}, 32'd0);
        check("reset done", {31'd0, done1}, 32'd0);
        check("reset idx", {30'd0, idx1}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++)
            do_add(vecs[i].av, vecs[i].bv, vecs[i].cv, vecs[i].exp);
        @(posedge clk); #1;

        // Second start edge and operand change during ADD are ignored.
        r0 = rises1;
        a = 4'b0101; b = 4'b0011; cin = 1'b0; start1 = 1'b1;
        q1.push_back(5'b01000);
        @(posedge clk); #1;              // k
        start1 = 1'b0;
        @(posedge clk); #1;              // k+1
        start1 = 1'b1;
        @(posedge clk); #1;              // k+2 load
        check("ignore busy at load", {31'd0, busy1}, 32'd1);
        a = 4'b0000; b = 4'b1111; cin = 1'b1;
        for (int c = 3; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c <= 5)
                check("ignore result held", {27'd0, cout1, sum1}, {27'd0, last_exp1});
        end
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("ignore single done rise", rises1 - r0, 32'd1);
        check("ignore result kept", {27'd0, cout1, sum1}, 32'b01000);

        // Reset in the middle of an add.
        a = 4'b1010; b = 4'b0110; cin = 1'b0; start1 = 1'b1;
        q1.push_back(5'b10000);
        n = 0;
        while (idx1 != 2'd2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached bit 2", {30'd0, idx1}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("async rst sum", {28'd0, sum1}, 32'd0);
        check("async rst cout", {31'd0, cout1}, 32'd0);
        check("async rst busy", {31'd0, busy1}, 32'd0);
        check("async rst done", {31'd0, done1}, 32'd0);
        check("async rst idx", {30'd0, idx1}, 32'd0);
        q1.delete();
        last_exp1 = '0;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle after reset busy", {31'd0, busy1}, 32'd0);
        do_add(4'b0110, 4'b0111, 1'b0, 5'b01101);
        @(posedge clk); #1;

        // Start held high across reset release gives exactly one add.
        rst_n = 1'b0;
        start1 = 1'b1; a = 4'b0011; b = 4'b0100; cin = 1'b1;
        last_exp1 = '0;
        r0 = rises1;
        q1.push_back(5'b01000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (!done1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("held start done", {31'd0, done1}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("held start one rise", rises1 - r0, 32'd1);
        start1 = 1'b0;

        // Slow stepping on dut3.
        a = 4'b0101; b = 4'b0011; cin = 1'b0; start3 = 1'b1;
        q3.push_back(5'b01000);
        @(posedge clk); #1;              // k
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (c == 3) start3 = 1'b0;
            exp_idx = (c < 5 || c == 14) ? 0 : (c - 2) / 3;
            check("slow bit index", {30'd0, idx3}, exp_idx);
            if (c == 13) check("slow done not early", {31'd0, done3}, 32'd0);
            if (c == 14) check("slow done at k+14", {31'd0, done3}, 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        a = 4'b1111; b = 4'b0001; cin = 1'b1; start3 = 1'b1;
        q3.push_back(5'b10001);
        @(posedge clk); #1;              // m
        @(posedge clk); #1;              // m+1
        check("slow done held pre-load", {31'd0, done3}, 32'd1);
        @(posedge clk); #1;              // m+2
        check("slow done cleared at load", {31'd0, done3}, 32'd0);
        check("slow busy at load", {31'd0, busy3}, 32'd1);
        check("slow old result held", {27'd0, cout3, sum3}, 32'b01000);
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("slow second done", {31'd0, done3}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("dut1 queue drained", q1.size(), 32'd0);
        check("dut3 queue drained", q3.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
